// File: rtl/pc_sequencer.sv
// MIPS fetch PC sequencer: sequential advance by 4 plus branch > jr > jump redirects.
// Define PC_DELAY_SLOT_EN to use the architectural delay slot instead of a flush pulse.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_addr,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        addr_err,
  output logic        nest_err
);

  logic        req;
  logic [31:0] target;
  logic [31:0] aligned;
  logic        misaligned;

  always_comb begin
    req    = branch_en | jr_en | jump_en;
    target = jump_addr;
    if (branch_en)  target = branch_addr;
    else if (jr_en) target = jr_addr;
  end

  assign aligned    = {target[31:2], 2'b00};
  assign misaligned = |target[1:0];
  assign pc_plus4   = pc + 32'd4;

`ifdef PC_DELAY_SLOT_EN
  logic        pending;
  logic [31:0] pending_target;

  assign flush = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      pending        <= 1'b0;
      pending_target <= 32'h0;
      addr_err       <= 1'b0;
      nest_err       <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      nest_err <= 1'b0;
      if (!stall) begin
        if (pending) begin
          // Delay slot has been fetched; a request issued from it is dropped.
          pc       <= pending_target;
          pending  <= 1'b0;
          nest_err <= req;
        end else begin
          pc <= pc_plus4;
          if (req) begin
            pending        <= 1'b1;
            pending_target <= aligned;
            addr_err       <= misaligned;
          end
        end
      end
    end
  end
`else
  assign nest_err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      flush    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      flush    <= 1'b0;
      addr_err <= 1'b0;
      if (!stall) begin
        if (req) begin
          pc       <= aligned;
          flush    <= 1'b1;
          addr_err <= misaligned;
        end else begin
          pc <= pc_plus4;
        end
      end
    end
  end
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS fetch stage. It holds the architectural PC and advances it by 4 each non-stalled cycle. It takes redirect requests from the jump-target path (pseudo-direct jump address), the branch comparator and the register-jump (jr) path. It produces the fetch PC, PC+4 for link and jump-region computation, and a flush pulse that squashes a wrongly fetched instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and all internal state this cycle.
- branch_en  in  1  taken-branch redirect request.
- branch_addr  in  32  branch target.
- jr_en  in  1  register-jump redirect request.
- jr_addr  in  32  register-jump target.
- jump_en  in  1  j/jal redirect request.
- jump_addr  in  32  pseudo-direct target {pc[31:28], instr_index, 2'b00}.
- pc  out  32  current fetch address (registered).
- pc_plus4  out  32  pc + 4, combinational, modulo 2^32.
- flush  out  1  registered one-cycle pulse: instruction at pc-4 path must be squashed.
- addr_err  out  1  registered one-cycle pulse: accepted target had target[1:0] != 0.
- nest_err  out  1  registered one-cycle pulse: redirect dropped because one was already pending.

## Operation
- Reset (rst=1, overrides stall): pc=RESET_PC, pending=0, pending_target=0, flush=0, addr_err=0, nest_err=0.
- Redirect requests are sampled only on cycles with stall=0. During stall, upstream holds its request.
- Priority when several requests are asserted: branch_en > jr_en > jump_en. Lower-priority requests in the same cycle are discarded silently.
- Selected target is forced word aligned: {target[31:2], 2'b00}. If target[1:0] != 0, addr_err pulses.
- With no request, next pc = pc_plus4. Wrap-around: 32'hFFFF_FFFC -> 32'h0000_0000, with no error.
- Redirect without delay slot: next pc = target; flush=1 for the following cycle.
- Redirect with delay slot: see Configuration.
- flush, addr_err and nest_err are 0 on any cycle not immediately following an accepted event.
- While stall=1, all three pulse outputs are driven 0 and pc holds.

## Timing
- Request accepted in cycle N (stall=0). pc changes at the clk edge ending cycle N.
- No delay slot: pc=target in N+1, flush=1 in N+1 only.
- Delay slot: pc=pc_N+4 in N+1, pc=target in the next non-stalled cycle after N+1; flush stays 0.
- Stall inserted between a delay-slot cycle and its target: pending is held, and the target is loaded on the first cycle with stall=0.
- Reset asserted while pending=1: pending is cleared and the target is lost; pc=RESET_PC next cycle.
- pc_plus4 has zero latency relative to pc.

## Configuration
- Macro PC_DELAY_SLOT_EN.
- Defined: MIPS architectural branch delay slot.
  - On accept: pending<=1, pending_target<=aligned target, pc<=pc+4.
  - Next advancing cycle: pc<=pending_target, pending<=0.
  - A request arriving while pending=1 is dropped and nest_err pulses; pending_target is unchanged.
  - flush is never asserted; output held 0.
- Not defined: no pending register.
  - Redirects take effect immediately with the flush pulse.
  - nest_err is tied 0.

## Test plan
- Reset/sequential: rst 1 cycle with RESET_PC=32'h0040_0000, then 3 free cycles -> pc 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; all pulse outputs 0.
- Jump: at pc=0x0040_0010, jump_en=1, jump_addr=0x0040_0100 -> no DS: pc=0x0040_0100 and flush=1 next cycle. DS: pc=0x0040_0014, then 0x0040_0100, flush=0.
- Priority and alignment: branch_en (0x0000_0200), jr_en (0x0000_0300) and jump_en (0x0000_0400) together -> branch wins. Then jr_addr=0x0000_0302 alone -> pc=0x0000_0300, addr_err=1 for one cycle.
- Stall: stall=1 for 3 cycles with jump_en held -> pc constant, no pulses. Stall released -> redirect taken once. DS: stall during the delay-slot cycle -> target loaded on the first unstalled cycle.
- Wrap and nesting: pc=0xFFFF_FFFC free-running -> 0x0000_0000. DS: second jump_en on the delay-slot cycle -> nest_err=1 and the original target is still reached.
- Reset mid-pending (DS): rst in the cycle after accept -> pc=RESET_PC, target never loaded.
